// File: rtl/nios2_oci_trace_capture.sv
// Trace capture: session FSM plus a first-word fall-through FIFO of {count, buffer} words.
// Latency: a word pushed on edge N is visible on rd_valid/rd_data after edge N.
// Backpressure: the consumer throttles with rd_ready; pushes into a full FIFO with no pop are dropped and counted.
module nios2_oci_trace_capture #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         arm,
  input  logic                         dct_valid,
  input  logic [DATA_W-1:0]            dct_buffer,
  input  logic [CNT_W-1:0]             dct_count,
  input  logic                         test_ending,
  input  logic                         test_has_ended,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [DATA_W+CNT_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow,
  output logic [7:0]                   drop_cnt,
  output logic [1:0]                   state,
  output logic                         done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + CNT_W;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             cur_state;
  state_t             nxt_state;
  logic               push_req;
  logic               arm_accept;
  logic               cnt_nz;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENT_W-1:0]   mem [DEPTH];

  assign cnt_nz     = (dct_count != '0);
  assign arm_accept = arm && ((cur_state == IDLE) || (cur_state == DONE));
  assign full       = (level == FULL_LVL);
  assign rd_valid   = (level != '0);
  // An accepted arm clears the FIFO, so it wins over a pop in the same cycle.
  assign pop        = rd_valid && rd_ready && !arm_accept;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign push_ok    = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;
  assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
  assign state      = cur_state;
  assign done       = (cur_state == DONE);

  // Session state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state and push-request decode; only CAPTURE ever produces a push.
  always_comb begin
    nxt_state = cur_state;
    push_req  = 1'b0;
    case (cur_state)
      IDLE: begin
        if (arm) nxt_state = CAPTURE;
      end
      CAPTURE: begin
        if (test_ending) begin
          // Flush the partial word whether or not it was marked complete.
          push_req = cnt_nz;
        end else begin
          push_req = dct_valid && cnt_nz;
        end
        if (test_has_ended) begin
          nxt_state = DONE;
        end else if (test_ending) begin
          nxt_state = FLUSH;
        end
      end
      FLUSH: begin
        if (test_has_ended) nxt_state = DONE;
      end
      DONE: begin
        if (arm) nxt_state = CAPTURE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // FIFO pointers, occupancy and drop accounting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (arm_accept) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push_ok) begin
        level <= level - LVL_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Storage array; contents are don't-care until written, rd_data masks empty reads.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {dct_count, dct_buffer};
  end

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Directed bench for nios2_oci_trace_capture with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Each check is an immediate assertion that counts and reports a miscompare.
module tb_nios2_oci_trace_capture;

  logic        clk;
  logic        reset_n;
  logic        arm;
  logic        dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  logic        rd_ready;
  logic        rd_valid;
  logic [33:0] rd_data;
  logic [4:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [1:0]  state;
  logic        done;

  int vectors;
  int miscompares;

  nios2_oci_trace_capture #(.DATA_W(30), .CNT_W(4), .DEPTH(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .arm            (arm),
    .dct_valid      (dct_valid),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .level          (level),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt),
    .state          (state),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] word(input logic [3:0] c, input logic [29:0] b);
    return {c, b};
  endfunction

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset_n        = 1'b0;
    arm            = 1'b0;
    dct_valid      = 1'b0;
    dct_buffer     = '0;
    dct_count      = '0;
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    rd_ready       = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_state",    64'(state),    64'd0);
    chk("rst_level",    64'(level),    64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_rd_data",  64'(rd_data),  64'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_after_rst", 64'(state), 64'd0);

    // Arm from IDLE
    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_to_capture", 64'(state), 64'd1);

    // Basic capture: three words with count 4
    dct_valid = 1'b1; dct_count = 4'd4;
    dct_buffer = 30'h1; tick();
    chk("fwft_first", 64'(rd_data), 64'(word(4'd4, 30'h1)));
    dct_buffer = 30'h2; tick();
    dct_buffer = 30'h3; tick();
    dct_valid = 1'b0;
    chk("basic_level3", 64'(level), 64'd3);
    tick();
    chk("basic_hold", 64'(rd_data), 64'(word(4'd4, 30'h1)));
    rd_ready = 1'b1;
    chk("basic_rd0", 64'(rd_data), 64'(word(4'd4, 30'h1)));
    tick();
    chk("basic_rd1", 64'(rd_data), 64'(word(4'd4, 30'h2)));
    tick();
    chk("basic_rd2", 64'(rd_data), 64'(word(4'd4, 30'h3)));
    tick();
    rd_ready = 1'b0;
    chk("basic_empty_level", 64'(level),    64'd0);
    chk("basic_empty_vld",   64'(rd_valid), 64'd0);

    // dct_valid with count 0 pushes nothing
    dct_valid = 1'b1; dct_count = 4'd0; dct_buffer = 30'h3F; tick();
    dct_valid = 1'b0;
    chk("count0_nopush", 64'(level), 64'd0);

    // Arm in CAPTURE is ignored and does not clear
    dct_valid = 1'b1; dct_count = 4'd1; dct_buffer = 30'h5; tick();
    dct_valid = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_ign_level", 64'(level), 64'd1);
    chk("arm_ign_state", 64'(state), 64'd1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("arm_ign_drain", 64'(level), 64'd0);

    // Flush of the partial word
    test_ending = 1'b1; dct_count = 4'd2; dct_buffer = 30'h2A; tick();
    test_ending = 1'b0;
    chk("flush_state", 64'(state),   64'd2);
    chk("flush_level", 64'(level),   64'd1);
    chk("flush_word",  64'(rd_data), 64'(word(4'd2, 30'h2A)));
    dct_valid = 1'b1; dct_count = 4'd1; dct_buffer = 30'h77; tick();
    dct_valid = 1'b0;
    chk("flush_ign_valid", 64'(level), 64'd1);
    test_has_ended = 1'b1; tick(); test_has_ended = 1'b0;
    chk("done_flag",  64'(done),  64'd1);
    chk("done_state", 64'(state), 64'd3);
    dct_valid = 1'b1; tick(); dct_valid = 1'b0;
    chk("done_nopush", 64'(level), 64'd1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("done_readout", 64'(level), 64'd0);

    // Re-arm from DONE, then overflow with 20 pushes and no reads
    arm = 1'b1; tick(); arm = 1'b0;
    chk("rearm_state", 64'(state), 64'd1);
    dct_valid = 1'b1; dct_count = 4'd3;
    for (int i = 0; i < 20; i++) begin
      dct_buffer = 30'(32'h100 + i);
      tick();
    end
    dct_valid = 1'b0;
    chk("ovf_level",    64'(level),    64'd16);
    chk("ovf_flag",     64'(overflow), 64'd1);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd4);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_rd%0d", i), 64'(rd_data), 64'(word(4'd3, 30'(32'h100 + i))));
      tick();
    end
    rd_ready = 1'b0;
    chk("ovf_drained", 64'(level), 64'd0);

    // Close via direct test_has_ended, re-arm clears sticky status
    test_has_ended = 1'b1; tick(); test_has_ended = 1'b0;
    chk("capture_to_done", 64'(state), 64'd3);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("rearm_clr_ovf",  64'(overflow), 64'd0);
    chk("rearm_clr_drop", 64'(drop_cnt), 64'd0);

    // Full FIFO with simultaneous push and pop
    dct_valid = 1'b1; dct_count = 4'd1;
    for (int i = 0; i < 16; i++) begin
      dct_buffer = 30'(32'h200 + i);
      tick();
    end
    chk("full_level", 64'(level), 64'd16);
    dct_count = 4'd7; dct_buffer = 30'h3FF; rd_ready = 1'b1; tick();
    dct_valid = 1'b0; rd_ready = 1'b0;
    chk("fullrw_level", 64'(level),    64'd16);
    chk("fullrw_ovf",   64'(overflow), 64'd0);
    chk("fullrw_head",  64'(rd_data),  64'(word(4'd1, 30'h201)));
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("fullrw_last", 64'(rd_data), 64'(word(4'd7, 30'h3FF)));
      else         chk($sformatf("fullrw_rd%0d", i), 64'(rd_data), 64'(word(4'd1, 30'(32'h201 + i))));
      tick();
    end
    rd_ready = 1'b0;
    chk("fullrw_drained", 64'(level), 64'd0);

    // Arm in DONE with 5 entries clears the FIFO
    dct_valid = 1'b1; dct_count = 4'd2;
    for (int i = 0; i < 5; i++) begin
      dct_buffer = 30'(32'h300 + i);
      tick();
    end
    dct_valid = 1'b0;
    test_has_ended = 1'b1; tick(); test_has_ended = 1'b0;
    chk("done5_level", 64'(level), 64'd5);
    arm = 1'b1; rd_ready = 1'b1; tick(); arm = 1'b0; rd_ready = 1'b0;
    chk("arm_done_level", 64'(level),    64'd0);
    chk("arm_done_state", 64'(state),    64'd1);
    chk("arm_done_vld",   64'(rd_valid), 64'd0);

    // Drop counter saturates at 255
    dct_valid = 1'b1; dct_count = 4'd1;
    for (int i = 0; i < 16 + 260; i++) begin
      dct_buffer = 30'(i);
      tick();
    end
    dct_valid = 1'b0;
    chk("sat_drop_cnt", 64'(drop_cnt), 64'd255);
    chk("sat_level",    64'(level),    64'd16);

    // Reset mid-session with level 7 acts without a clock edge
    test_has_ended = 1'b1; tick(); test_has_ended = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    dct_valid = 1'b1; dct_count = 4'd5;
    for (int i = 0; i < 7; i++) begin
      dct_buffer = 30'(32'h400 + i);
      tick();
    end
    dct_valid = 1'b0;
    chk("pre_rst_level", 64'(level), 64'd7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_level",   64'(level),    64'd0);
    chk("async_rst_state",   64'(state),    64'd0);
    chk("async_rst_vld",     64'(rd_valid), 64'd0);
    chk("async_rst_rd_data", 64'(rd_data),  64'd0);
    #2;
    reset_n = 1'b1;
    tick();
    dct_valid = 1'b1; dct_count = 4'd1; tick(); tick();
    dct_valid = 1'b0;
    chk("post_rst_idle",   64'(state), 64'd0);
    chk("post_rst_nopush", 64'(level), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
